line_drawer: RTL

//  Rasterises one straight segment (x1,y1)-(x2,y2) into framebuffer pixel writes using integer Bresenham.

---
 rtl/line_drawer_pkg.sv | 27 ++
 rtl/line_drawer_bresenham_step.sv | 66 ++++++
 rtl/line_drawer.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/line_drawer_pkg.sv
// ---------------------------------------------------------------------------
// line_drawer_pkg
// Shared definitions for the Bresenham line drawer:
//   - state_e   : controller FSM encoding (IDLE / SETUP / RUN)
//   - STEP_POS / STEP_NEG : encoding of the per-axis walk direction bit
//   - calc_w()  : signed width of the error/delta datapath, wide enough
//                 that dx, dy, err and 2*err never overflow for any
//                 in-range endpoint pair.
// ---------------------------------------------------------------------------
package line_drawer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    // Direction bit: 0 walks towards larger coordinates, 1 towards smaller.
    localparam logic STEP_POS = 1'b0;
    localparam logic STEP_NEG = 1'b1;

    // One bit for the sign and one for the doubling in e2 = 2*err.
    function automatic int calc_w(input int x_width, input int y_width);
        return ((x_width > y_width) ? x_width : y_width) + 2;
    endfunction

endpackage

// File: rtl/line_drawer_bresenham_step.sv
// ---------------------------------------------------------------------------
// bresenham_step
// Purely combinational single step of integer Bresenham.
// Ports:
//   cur_x/cur_y   in   current pixel
//   end_x/end_y   in   segment end point
//   err, dx, dy   in   signed error term and deltas (dx >= 0, dy <= 0)
//   sx, sy        in   direction bits (STEP_POS / STEP_NEG)
//   nxt_x/nxt_y   out  pixel after this step
//   nxt_err       out  error term after this step
//   at_end        out  current pixel is the segment end point
// ---------------------------------------------------------------------------
module bresenham_step
    import line_drawer_pkg::*;
#(
    parameter int X_WIDTH = 10,
    parameter int Y_WIDTH = 9,
    parameter int W       = 12
)(
    input  logic [X_WIDTH-1:0]  cur_x,
    input  logic [Y_WIDTH-1:0]  cur_y,
    input  logic [X_WIDTH-1:0]  end_x,
    input  logic [Y_WIDTH-1:0]  end_y,
    input  logic signed [W-1:0] err,
    input  logic signed [W-1:0] dx,
    input  logic signed [W-1:0] dy,
    input  logic                sx,
    input  logic                sy,
    output logic [X_WIDTH-1:0]  nxt_x,
    output logic [Y_WIDTH-1:0]  nxt_y,
    output logic signed [W-1:0] nxt_err,
    output logic                at_end
);

    localparam logic [X_WIDTH-1:0] ONE_X  = {{(X_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [Y_WIDTH-1:0] ONE_Y  = {{(Y_WIDTH-1){1'b0}}, 1'b1};
    localparam logic signed [W-1:0] ZERO_W = '0;

    logic signed [W-1:0] e2;
    logic                step_x;
    logic                step_y;

    // NOTE: every signal written in an always_comb gets a value on every path
    // (defaults first), otherwise synthesis infers a latch.
    always_comb begin
        e2     = err <<< 1;
        // Both decisions use the same e2; their error updates are summed.
        step_x = (e2 >= dy);
        step_y = (e2 <= dx);

        nxt_err = err + (step_x ? dy : ZERO_W) + (step_y ? dx : ZERO_W);

        nxt_x = cur_x;
        if (step_x) begin
            nxt_x = (sx == STEP_NEG) ? (cur_x - ONE_X) : (cur_x + ONE_X);
        end

        nxt_y = cur_y;
        if (step_y) begin
            nxt_y = (sy == STEP_NEG) ? (cur_y - ONE_Y) : (cur_y + ONE_Y);
        end

        at_end = (cur_x == end_x) && (cur_y == end_y);
    end

endmodule

// File: rtl/line_drawer.sv
// ---------------------------------------------------------------------------
// line_drawer
// Rasterises one segment (x1,y1)-(x2,y2) into a stream of pixel writes,
// both endpoints inclusive, at most one pixel per clock.
// Ports:
//   clk, reset              clock; asynchronous active-high reset
//   start / ready           request handshake from the plot controller
//   x1, y1, x2, y2          segment endpoints, captured on the start cycle
//   pixel_valid / ready     pixel handshake towards the framebuffer
//   pixel_x, pixel_y        pixel coordinates
// Configuration macro:
//   LINE_DRAWER_CLIP_EN     when defined, off-screen pixels are walked
//                           internally (one per cycle) but never presented.
// ---------------------------------------------------------------------------
module line_drawer
    import line_drawer_pkg::*;
#(
    parameter  int HOR_ACTIVE_PIXELS = 640,
    parameter  int VER_ACTIVE_PIXELS = 480,
    localparam int X_WIDTH = $clog2(HOR_ACTIVE_PIXELS),
    localparam int Y_WIDTH = $clog2(VER_ACTIVE_PIXELS)
)(
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               ready,
    input  logic [X_WIDTH-1:0] x1,
    input  logic [Y_WIDTH-1:0] y1,
    input  logic [X_WIDTH-1:0] x2,
    input  logic [Y_WIDTH-1:0] y2,
    output logic               pixel_valid,
    output logic [X_WIDTH-1:0] pixel_x,
    output logic [Y_WIDTH-1:0] pixel_y,
    input  logic               pixel_ready
);

    localparam int W = calc_w(X_WIDTH, Y_WIDTH);

    state_e              state_q, state_d;
    logic [X_WIDTH-1:0]  x1_q, x1_d, x2_q, x2_d, cur_x_q, cur_x_d;
    logic [Y_WIDTH-1:0]  y1_q, y1_d, y2_q, y2_d, cur_y_q, cur_y_d;
    logic signed [W-1:0] dx_q, dx_d, dy_q, dy_d, err_q, err_d;
    logic                sx_q, sx_d, sy_q, sy_d;

    logic [X_WIDTH-1:0]  nxt_x;
    logic [Y_WIDTH-1:0]  nxt_y;
    logic signed [W-1:0] nxt_err;
    logic                at_end;
    logic                on_screen;
    logic                advance;

    // Endpoints zero-extended into the signed datapath for the SETUP deltas.
    logic signed [W-1:0] x1_s, x2_s, y1_s, y2_s, abs_dx, abs_dy;

    assign x1_s = signed'({{(W-X_WIDTH){1'b0}}, x1_q});
    assign x2_s = signed'({{(W-X_WIDTH){1'b0}}, x2_q});
    assign y1_s = signed'({{(W-Y_WIDTH){1'b0}}, y1_q});
    assign y2_s = signed'({{(W-Y_WIDTH){1'b0}}, y2_q});
    assign abs_dx = (x2_s >= x1_s) ? (x2_s - x1_s) : (x1_s - x2_s);
    assign abs_dy = (y2_s >= y1_s) ? (y2_s - y1_s) : (y1_s - y2_s);

`ifdef LINE_DRAWER_CLIP_EN
    localparam logic [X_WIDTH:0] X_LIMIT = (X_WIDTH+1)'(HOR_ACTIVE_PIXELS);
    localparam logic [Y_WIDTH:0] Y_LIMIT = (Y_WIDTH+1)'(VER_ACTIVE_PIXELS);
    assign on_screen = ({1'b0, cur_x_q} < X_LIMIT) && ({1'b0, cur_y_q} < Y_LIMIT);
`else
    assign on_screen = 1'b1;
`endif

    // Off-screen pixels are skipped without waiting for the framebuffer.
    assign advance = (state_q == ST_RUN) && (pixel_ready || !on_screen);

    bresenham_step #(
        .X_WIDTH (X_WIDTH),
        .Y_WIDTH (Y_WIDTH),
        .W       (W)
    ) u_step (
        .cur_x   (cur_x_q),
        .cur_y   (cur_y_q),
        .end_x   (x2_q),
        .end_y   (y2_q),
        .err     (err_q),
        .dx      (dx_q),
        .dy      (dy_q),
        .sx      (sx_q),
        .sy      (sy_q),
        .nxt_x   (nxt_x),
        .nxt_y   (nxt_y),
        .nxt_err (nxt_err),
        .at_end  (at_end)
    );

    always_comb begin
        state_d = state_q;
        x1_d    = x1_q;
        y1_d    = y1_q;
        x2_d    = x2_q;
        y2_d    = y2_q;
        cur_x_d = cur_x_q;
        cur_y_d = cur_y_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        err_d   = err_q;
        sx_d    = sx_q;
        sy_d    = sy_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    x1_d    = x1;
                    y1_d    = y1;
                    x2_d    = x2;
                    y2_d    = y2;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                dx_d    = abs_dx;
                dy_d    = -abs_dy;
                err_d   = abs_dx - abs_dy;
                sx_d    = (x2_q >= x1_q) ? STEP_POS : STEP_NEG;
                sy_d    = (y2_q >= y1_q) ? STEP_POS : STEP_NEG;
                cur_x_d = x1_q;
                cur_y_d = y1_q;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (advance) begin
                    if (at_end) begin
                        state_d = ST_IDLE;
                    end else begin
                        cur_x_d = nxt_x;
                        cur_y_d = nxt_y;
                        err_d   = nxt_err;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its inputs regardless of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            x1_q    <= '0;
            y1_q    <= '0;
            x2_q    <= '0;
            y2_q    <= '0;
            cur_x_q <= '0;
            cur_y_q <= '0;
            dx_q    <= '0;
            dy_q    <= '0;
            err_q   <= '0;
            sx_q    <= STEP_POS;
            sy_q    <= STEP_POS;
        end else begin
            state_q <= state_d;
            x1_q    <= x1_d;
            y1_q    <= y1_d;
            x2_q    <= x2_d;
            y2_q    <= y2_d;
            cur_x_q <= cur_x_d;
            cur_y_q <= cur_y_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            err_q   <= err_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
        end
    end

    assign ready       = (state_q == ST_IDLE);
    assign pixel_valid = (state_q == ST_RUN) && on_screen;
    assign pixel_x     = cur_x_q;
    assign pixel_y     = cur_y_q;

endmodule
